serial_key_matrix: RTL and testbench

//  Converts the ASCII byte stream from uart_rx into timed presses on the 64-key Galaksija matrix.

---
 rtl/serial_key_matrix.sv | 177 +++++++++++++++++
 tb/tb_serial_key_matrix.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_key_matrix.sv
// serial_key_matrix: turns the ASCII byte stream from uart_rx into timed key
// presses on the 64-key Galaksija matrix read by the CPU at 0x2000-0x27FF.
// Bytes are decoded to {shift, key} on entry to a small FIFO; an FSM then
// holds each key for HOLD_CYCLES and releases everything for GAP_CYCLES so
// repeated characters are seen by the ROM scan as separate presses.
module serial_key_matrix #(
    parameter int HOLD_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int FIFO_AW     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rd_key,
    input  logic [5:0] key_addr,
    output logic [7:0] key_out,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [5:0] SHIFT_KEY = 6'd53;

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    // Returns {mapped, shift, key[5:0]}; mapped=0 means the byte is ignored.
    function automatic logic [7:0] decode_byte(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) begin
            // Letters of either case share bits [4:0] = 1..26
            r = {3'b100, b[4:0]};
        end else if (b >= 8'h30 && b <= 8'h39) begin
            r = {2'b10, b[5:0] - 6'd16};
        end else begin
            case (b)
                8'h0A, 8'h0D: r = {2'b10, 6'd48};
                8'h08, 8'h7F: r = {2'b10, 6'd29};
                8'h1B:        r = {2'b10, 6'd49};
                8'h20:        r = {2'b10, 6'd31};
                8'h3B:        r = {2'b10, 6'd42};   // ;
                8'h3A:        r = {2'b10, 6'd43};   // :
                8'h2C:        r = {2'b10, 6'd44};   // ,
                8'h3D:        r = {2'b10, 6'd45};   // =
                8'h2E:        r = {2'b10, 6'd46};   // .
                8'h2F:        r = {2'b10, 6'd47};   // /
                8'h5F:        r = {2'b11, 6'd32};   // _
                8'h21:        r = {2'b11, 6'd33};   // !
                8'h22:        r = {2'b11, 6'd34};   // "
                8'h23:        r = {2'b11, 6'd35};   // #
                8'h24:        r = {2'b11, 6'd36};   // $
                8'h25:        r = {2'b11, 6'd37};   // %
                8'h26:        r = {2'b11, 6'd38};   // &
                8'h5C:        r = {2'b11, 6'd39};   // backslash
                8'h28:        r = {2'b11, 6'd40};   // (
                8'h29:        r = {2'b11, 6'd41};   // )
                8'h2B:        r = {2'b11, 6'd42};   // +
                8'h2A:        r = {2'b11, 6'd43};   // *
                8'h3C:        r = {2'b11, 6'd44};   // <
                8'h2D:        r = {2'b11, 6'd45};   // -
                8'h3E:        r = {2'b11, 6'd46};   // >
                8'h3F:        r = {2'b11, 6'd47};   // ?
                default:      r = '0;
            endcase
        end
        return r;
    endfunction

    logic [6:0]         fifo_mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic               fifo_empty;
    logic [7:0]         dec;
    logic               push;
    logic               drop;
    logic               pop;
    logic [6:0]         head;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        matrix_q, matrix_d;

    assign dec        = decode_byte(rx_data);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    // Fullness is judged on registered pointers, so a same-cycle pop never admits a byte
    assign push       = rx_valid && dec[7] && !fifo_full;
    assign drop       = rx_valid && dec[7] && fifo_full;
    assign head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign busy       = (state_q != IDLE) || !fifo_empty;

    // FIFO storage: data only, no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= dec[6:0];
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    // Press/gap sequencer state, counter and key matrix registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            matrix_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            matrix_q <= matrix_d;
        end
    end

    // Next-state logic: pop one entry, hold it, then release all keys for the gap
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        matrix_d = matrix_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop                = 1'b1;
                    matrix_d[head[5:0]] = 1'b1;
                    if (head[6]) matrix_d[SHIFT_KEY] = 1'b1;
                    cnt_d              = HOLD_LOAD;
                    state_d            = PRESS;
                end
            end
            PRESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    matrix_d = '0;
                    cnt_d    = GAP_LOAD;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // CPU keyboard read: latch the addressed key, hold value between reads
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_out <= 8'hFF;
        end else if (rd_key) begin
            key_out <= matrix_q[key_addr] ? 8'hFE : 8'hFF;
        end
    end

endmodule

// File: tb/tb_serial_key_matrix.sv
// Directed bench for serial_key_matrix with HOLD=8, GAP=4, FIFO depth 4.
module tb_serial_key_matrix;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rd_key = 1'b0;
    logic [5:0] key_addr = 6'd0;
    logic [7:0] key_out;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx_q[$];
    bit fe_log   [128];
    bit busy_log [128];
    bit full_log [128];
    bit ovf_log  [128];

    int presses, n_fe, first_fe, last_busy, busy_cnt;

    serial_key_matrix #(
        .HOLD_CYCLES (8),
        .GAP_CYCLES  (4),
        .FIFO_AW     (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rd_key    (rd_key),
        .key_addr  (key_addr),
        .key_out   (key_out),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n  = 1'b1;
    endtask

    // Send tx_q one byte per cycle (first sampled at edge 0), log outputs after each edge
    task automatic run_seq(input int ncyc);
        int idx;
        idx = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (idx < tx_q.size()) begin
                rx_data  = tx_q[idx];
                rx_valid = 1'b1;
                idx++;
            end else begin
                rx_valid = 1'b0;
            end
            tick();
            fe_log[c]   = (key_out == 8'hFE);
            busy_log[c] = busy;
            full_log[c] = fifo_full;
            ovf_log[c]  = overflow;
        end
        rx_valid = 1'b0;
        tx_q.delete();
    endtask

    task automatic analyse(input int ncyc);
        presses = 0; n_fe = 0; first_fe = -1; last_busy = -1; busy_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (fe_log[c]) begin
                n_fe++;
                if (first_fe < 0) first_fe = c;
                if (c == 0 || !fe_log[c-1]) presses++;
            end
            if (busy_log[c]) begin
                last_busy = c;
                busy_cnt++;
            end
        end
    endtask

    initial begin
        rd_key = 1'b1;
        do_reset();
        check("rst_key_out", 32'(key_out), 32'hFF);
        check("rst_busy", 32'(busy), 0);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_ovf", 32'(overflow), 0);

        // 'A' -> key 1, FE after edges 2..9, busy ends after edge 12
        key_addr = 6'd1;
        tx_q.push_back(8'h41);
        run_seq(30);
        analyse(30);
        check("A_first", 32'(first_fe), 2);
        check("A_len", 32'(n_fe), 8);
        check("A_presses", 32'(presses), 1);
        check("A_last_busy", 32'(last_busy), 12);
        check("A_busy_c0", 32'(busy_log[0]), 1);

        key_addr = 6'd53;
        tx_q.push_back(8'h41);
        run_seq(30);
        analyse(30);
        check("A_shift_key", 32'(n_fe), 0);

        // '"' -> keys 34 and 53 over the same window
        key_addr = 6'd34;
        tx_q.push_back(8'h22);
        run_seq(30);
        analyse(30);
        check("dq_k34_first", 32'(first_fe), 2);
        check("dq_k34_len", 32'(n_fe), 8);
        check("dq_k34_off", 32'(fe_log[10]), 0);
        key_addr = 6'd53;
        tx_q.push_back(8'h22);
        run_seq(30);
        analyse(30);
        check("dq_k53_first", 32'(first_fe), 2);
        check("dq_k53_len", 32'(n_fe), 8);
        check("dq_k53_off", 32'(fe_log[10]), 0);

        // lowercase and digit mapping
        key_addr = 6'd26;
        tx_q.push_back(8'h7A);
        run_seq(30);
        analyse(30);
        check("z_len", 32'(n_fe), 8);
        key_addr = 6'd41;
        tx_q.push_back(8'h39);
        run_seq(30);
        analyse(30);
        check("9_len", 32'(n_fe), 8);

        // "AA": press 8, release 5, press 8
        key_addr = 6'd1;
        tx_q.push_back(8'h41);
        tx_q.push_back(8'h61);
        run_seq(40);
        analyse(40);
        check("AA_presses", 32'(presses), 2);
        check("AA_len", 32'(n_fe), 16);
        check("AA_gap_lo", 32'(fe_log[14]), 0);
        check("AA_second", 32'(fe_log[15]), 1);
        check("AA_last_busy", 32'(last_busy), 25);

        // Six bytes into a depth-4 FIFO: one popped, four stored, sixth dropped
        key_addr = 6'd1;
        for (int i = 0; i < 6; i++) tx_q.push_back(8'h41);
        run_seq(80);
        analyse(80);
        check("ovf_full_c3", 32'(full_log[3]), 0);
        check("ovf_full_c4", 32'(full_log[4]), 1);
        check("ovf_flag_c4", 32'(ovf_log[4]), 0);
        check("ovf_flag_c5", 32'(ovf_log[5]), 1);
        check("ovf_presses", 32'(presses), 5);
        check("ovf_len", 32'(n_fe), 40);
        check("ovf_last_busy", 32'(last_busy), 64);
        check("ovf_sticky", 32'(overflow), 1);
        do_reset();
        check("ovf_rst_clear", 32'(overflow), 0);

        // Unmapped '~' is ignored
        tx_q.push_back(8'h7E);
        run_seq(10);
        analyse(10);
        check("tilde_busy", 32'(busy_cnt), 0);
        check("tilde_ovf", 32'(overflow), 0);

        // Reset mid-PRESS drops the pressed key and the queued one
        key_addr = 6'd1;
        tx_q.push_back(8'h41);
        tx_q.push_back(8'h42);
        run_seq(4);
        check("mid_pressed", 32'(key_out), 32'hFE);
        do_reset();
        check("mid_rst_key", 32'(key_out), 32'hFF);
        check("mid_rst_busy", 32'(busy), 0);
        tick();
        check("mid_k1_read", 32'(key_out), 32'hFF);
        key_addr = 6'd2;
        tick();
        check("mid_k2_read", 32'(key_out), 32'hFF);
        key_addr = 6'd33;
        tx_q.push_back(8'h31);
        run_seq(30);
        analyse(30);
        check("one_first", 32'(first_fe), 2);
        check("one_len", 32'(n_fe), 8);
        check("one_last_busy", 32'(last_busy), 12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
